// File: rtl/fixed_div_pkg.sv
// Shared helpers for the divider result queue: saturation constant and counter sizing.
package fixed_div_pkg;

  localparam int unsigned MaxWidth = 64;

  // All-ones of the given width; the sign bit is cleared for the signed variant.
  function automatic logic [MaxWidth-1:0] sat_const(input int unsigned width,
                                                    input bit is_signed);
    logic [MaxWidth-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    if (is_signed && width > 0) v[width-1] = 1'b0;
    return v;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/div_result_fifo.sv
// Power-of-two FIFO for divider results; no bypass, registered occupancy count.
module div_result_fifo
  import fixed_div_pkg::*;
#(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = cnt_width(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CntW'(Depth)) | do_pop);

  always_comb begin
    wptr_d  = wptr_q + PtrW'(do_push);
    rptr_d  = rptr_q + PtrW'(do_pop);
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fixed_div_result_queue.sv
// Credit-managed result queue behind a fixed-latency divider; results leave in issue order.
module fixed_div_result_queue
  import fixed_div_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LATENCY  = 12,
  parameter int unsigned DEPTH    = 8,
  parameter bit          SIGNED   = 1'b1,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             issueValid,
  output logic             issueReady,
  input  logic [WIDTH-1:0] divOut,
  input  logic             divByZero,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] out,
  output logic             outDivByZero,
  output logic             protocolError
);

  localparam int unsigned CntW    = cnt_width(DEPTH);
  localparam int unsigned FlightW = $clog2(LATENCY + 1);
  localparam int unsigned SumW    = $clog2(LATENCY + DEPTH + 1);
  localparam logic [WIDTH-1:0] SatVal = WIDTH'(sat_const(WIDTH, SIGNED));

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [FlightW-1:0] inflight_q, inflight_d;
  logic               err_q, err_d;
  logic               accept, emerge, pop;
  logic [WIDTH-1:0]   result;
  logic [CntW-1:0]    fifo_count;
  logic [WIDTH:0]     fifo_rdata;

  assign accept = issueValid & issueReady;
  assign emerge = valid_q[LATENCY-1];
  assign pop    = outValid & outReady;

  // Every launched operand holds a FIFO slot until popped, so emerge never overflows.
  assign issueReady = (SumW'(inflight_q) + SumW'(fifo_count)) < SumW'(DEPTH);

  assign result = (SATURATE && divByZero) ? SatVal : divOut;

  always_comb begin
    valid_d    = valid_q << 1;
    valid_d[0] = accept;
    inflight_d = inflight_q;
    if (accept && !emerge) begin
      inflight_d = inflight_q + FlightW'(1);
    end else if (!accept && emerge) begin
      inflight_d = inflight_q - FlightW'(1);
    end
    err_d = err_q | (issueValid & ~issueReady);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  div_result_fifo #(
    .Width(WIDTH + 1),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (clock),
    .rst_ni (resetn),
    .push_i (emerge),
    .wdata_i({result, divByZero}),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .valid_o(outValid),
    .count_o(fifo_count)
  );

  assign out           = fifo_rdata[WIDTH:1];
  assign outDivByZero  = fifo_rdata[0];
  assign protocolError = err_q;

endmodule

// File: tb/tb_fixed_div_result_queue.sv
// Bench for fixed_div_result_queue: four configurations driven by one directed stimulus,
// checked each cycle against a behavioural model plus hand-computed literals.
module tb_fixed_div_result_queue;

  localparam int L = 4;

  logic clock, resetn, issueValid, outReady, divByZero;
  logic [7:0] divOut;
  logic [3:0] ov, ir, pe, odz;
  logic [3:0][7:0] od;

  int checks = 0;
  int errors = 0;

  // Model state per depth class (0: DEPTH=4, 1: DEPTH=8).
  bit         acc_at [2][4096];
  logic [8:0] res    [2][1024];
  int         wr     [2];
  int         rd     [2];
  bit         err    [2];
  int         mcyc = 0;

  // Instance 0: signed saturate, 1: unsigned saturate, 2: no saturate, 3: DEPTH=8.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    fixed_div_result_queue #(
      .WIDTH   (8),
      .LATENCY (L),
      .DEPTH   ((g == 3) ? 8 : 4),
      .SIGNED  (g != 1),
      .SATURATE(g != 2)
    ) u_dut (
      .clock        (clock),
      .resetn       (resetn),
      .issueValid   (issueValid),
      .issueReady   (ir[g]),
      .divOut       (divOut),
      .divByZero    (divByZero),
      .outValid     (ov[g]),
      .outReady     (outReady),
      .out          (od[g]),
      .outDivByZero (odz[g]),
      .protocolError(pe[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xform(input logic [7:0] raw, input bit z, input int d);
    if (z && d != 2) return (d == 1) ? 8'hFF : 8'h7F;
    return raw;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 1) ? 8 : 4;
  endfunction

  task automatic model_cycle();
    int infl;
    int cnt;
    int k;
    bit rdy [2];
    logic [8:0] head;
    if (!resetn) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("d%0d.rst.outValid", d), ov[d], 0);
        chk($sformatf("d%0d.rst.issueReady", d), ir[d], 1);
        chk($sformatf("d%0d.rst.protocolError", d), pe[d], 0);
        chk($sformatf("d%0d.rst.out", d), od[d], 0);
        chk($sformatf("d%0d.rst.outDivByZero", d), odz[d], 0);
      end
      for (int kk = 0; kk < 2; kk++) begin
        for (int a = mcyc - L; a <= mcyc; a++) if (a >= 0) acc_at[kk][a] = 1'b0;
        rd[kk]  = wr[kk];
        err[kk] = 1'b0;
      end
    end else begin
      for (int kk = 0; kk < 2; kk++) begin
        infl = 0;
        for (int a = mcyc - L; a < mcyc; a++) if (a >= 0) infl += int'(acc_at[kk][a]);
        rdy[kk] = (infl + wr[kk] - rd[kk]) < depth_of(kk);
      end
      for (int d = 0; d < 4; d++) begin
        k   = (d == 3) ? 1 : 0;
        cnt = wr[k] - rd[k];
        chk($sformatf("d%0d.outValid", d), ov[d], int'(cnt > 0));
        chk($sformatf("d%0d.issueReady", d), ir[d], int'(rdy[k]));
        chk($sformatf("d%0d.protocolError", d), pe[d], int'(err[k]));
        if (cnt > 0) begin
          head = res[k][rd[k]];
          chk($sformatf("d%0d.out", d), od[d], xform(head[8:1], head[0], d));
          chk($sformatf("d%0d.outDivByZero", d), odz[d], head[0]);
        end
      end
      for (int kk = 0; kk < 2; kk++) begin
        if (issueValid && !rdy[kk]) err[kk] = 1'b1;
        if (wr[kk] > rd[kk] && outReady) rd[kk]++;
        if (mcyc >= L && acc_at[kk][mcyc-L]) begin
          res[kk][wr[kk]] = {divOut, divByZero};
          wr[kk]++;
        end
        acc_at[kk][mcyc] = issueValid & rdy[kk];
      end
    end
    mcyc++;
  endtask

  initial forever begin
    @(negedge clock);
    model_cycle();
  end

  task automatic drive(input bit iv, input bit ordy, input logic [7:0] d, input bit z);
    @(posedge clock);
    #1;
    issueValid = iv;
    outReady   = ordy;
    divOut     = d;
    divByZero  = z;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    resetn = 1'b0;
    issueValid = 1'b0;
    outReady = 1'b0;
    divOut = '0;
    divByZero = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    issueValid = 1'b0;
    outReady = 1'b0;
    divOut = '0;
    divByZero = 1'b0;
    @(negedge clock);
    chk("reset issueReady", ir[0], 1);
    chk("reset outValid", ov[0], 0);

    // Single issue: result visible LATENCY+1 cycles after accept.
    do_reset();
    drive(1, 1, 8'h00, 0);
    repeat (3) drive(0, 1, 8'h00, 0);
    drive(0, 1, 8'h35, 0);
    @(negedge clock);
    chk("single.c4.outValid", ov[0], 0);
    drive(0, 1, 8'h00, 0);
    @(negedge clock);
    chk("single.c5.outValid", ov[0], 1);
    chk("single.c5.out", od[0], 8'h35);
    chk("single.c5.outDivByZero", odz[0], 0);

    // Divide-by-zero across the three saturation variants.
    do_reset();
    drive(1, 1, 8'h00, 0);
    repeat (3) drive(0, 1, 8'h00, 0);
    drive(0, 1, 8'h12, 1);
    drive(0, 1, 8'h00, 0);
    @(negedge clock);
    chk("dbz.signed.out", od[0], 8'h7F);
    chk("dbz.unsigned.out", od[1], 8'hFF);
    chk("dbz.nosat.out", od[2], 8'h12);
    chk("dbz.signed.flag", odz[0], 1);
    chk("dbz.unsigned.flag", odz[1], 1);
    chk("dbz.nosat.flag", odz[2], 1);

    // Back-pressure: credits run out, protocolError sticks, results drain in order.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, (c >= 4) ? 8'(8'hA0 + c - 4) : 8'h00, 0);
      @(negedge clock);
      if (c == 3) chk("bp.c3.issueReady", ir[0], 1);
      if (c == 4) chk("bp.c4.issueReady", ir[0], 0);
      if (c == 5) chk("bp.c5.protocolError", pe[0], 1);
    end
    drive(0, 0, 8'hA2, 0);
    drive(0, 0, 8'hA3, 0);
    for (int c = 8; c < 12; c++) begin
      drive(0, 1, 8'(8'hA0 + c - 4), 0);
      @(negedge clock);
      chk($sformatf("bp.c%0d.outValid", c), ov[0], 1);
      chk($sformatf("bp.c%0d.out", c), od[0], 8'hA0 + c - 8);
    end
    drive(0, 1, 8'h00, 0);
    @(negedge clock);
    chk("bp.c12.outValid", ov[0], 0);
    repeat (3) drive(0, 1, 8'h00, 0);

    // Push and pop together with one entry queued.
    do_reset();
    drive(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'hB0, 0);
    drive(0, 1, 8'hB1, 0);
    @(negedge clock);
    chk("pp.c5.out", od[0], 8'hB0);
    drive(0, 1, 8'h00, 0);
    @(negedge clock);
    chk("pp.c6.outValid", ov[0], 1);
    chk("pp.c6.out", od[0], 8'hB1);
    drive(0, 1, 8'h00, 0);
    @(negedge clock);
    chk("pp.c7.outValid", ov[0], 0);

    // Reset with two in flight and one queued discards everything.
    do_reset();
    repeat (3) drive(1, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'hC0, 0);
    drive(0, 0, 8'hC1, 1);
    @(negedge clock);
    chk("mrst.before.outValid", ov[0], 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mrst.now.outValid", ov[0], 0);
    chk("mrst.now.issueReady", ir[0], 1);
    @(posedge clock);
    #1;
    @(negedge clock);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 8'(8'hC2 + i), 1);
      @(negedge clock);
      chk($sformatf("mrst.idle%0d.outValid", i), ov[0], 0);
    end

    // Streaming into the deep instance: one result per cycle, never throttled.
    do_reset();
    for (int c = 0; c < 25; c++) begin
      drive(c < 20, 1, 8'(8'h40 + c - 4), 0);
      @(negedge clock);
      if (c < 20) chk($sformatf("stream.c%0d.issueReady", c), ir[3], 1);
      if (c >= 5) begin
        chk($sformatf("stream.c%0d.outValid", c), ov[3], 1);
        chk($sformatf("stream.c%0d.out", c), od[3], 8'h40 + c - 5);
      end
    end
    repeat (4) drive(0, 1, 8'h00, 0);

    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
